p256_mul_arbiter: RTL and testbench
===================================

# p256_mul_arbiter

Shares one 256×256 multiplier (the Rad4_mul_256 start-by-reset-pulse / done handshake) between `NREQ` requesters such as the squarer and the field multiplier. Round-robin arbitration, operand latching, start sequencing and result return are all handled here. The block sits between the P-256 arithmetic sequencers and the single multiplier instance and owns that multiplier's `rst_n`.

## Interface
- `NREQ`, default 2: number of requesters, valid range 2..8.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit. Used only with `P256_MUL_ARB_TIMEOUT_EN`.
- `clk  in  1`: clock. All state updates on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `ena  in  1`: global enable. When low, all state is frozen.
- `req_valid  in  NREQ`: per-requester operation request.
- `req_ready  out  NREQ`: one-hot accept. Combinational. Transfer happens when `req_valid[i] && req_ready[i]`.
- `req_x, req_y  in  NREQ*256`: operands, packed. Requester i occupies bits `[256*i+255 : 256*i]`.
- `rsp_valid  out  NREQ`: one-cycle, one-hot result strobe to the granted requester.
- `rsp_low, rsp_high  out  256`: product halves. Shared by all requesters. Valid while `rsp_valid` is high; hold value until the next response.
- `rsp_err  out  1`: timeout flag, qualified by `rsp_valid`.
- `busy  out  1`: high whenever not IDLE.
- `mul_x, mul_y  out  256`: registered operands to the multiplier.
- `mul_rst_n  out  1`: multiplier start. Driving it low for one cycle starts an operation.
- `mul_done  in  1`, `mul_low, mul_high  in  256`: multiplier completion flag and result.

## Operation
- FSM states and transitions:
  - IDLE → START on transfer.
  - START → GUARD.
  - GUARD → BUSY.
  - BUSY → RESP when `mul_done`.
  - RESP → IDLE.
- IDLE:
  - The arbiter picks the first valid requester at or after pointer `ptr`, searching upward and wrapping modulo `NREQ`.
  - `req_ready` is one-hot on the winner. It is all-zero when no requester is valid, when not in IDLE, or when `ena=0`.
  - On transfer: latch `req_x`/`req_y` of the winner into `mul_x`/`mul_y`, record the winner in `gid`, and set `ptr` to `(winner+1) mod NREQ`.
- START: `mul_rst_n=0` for exactly one enabled cycle.
- GUARD: `mul_rst_n=1`. `mul_done` is ignored in this state, which masks a stale done from the previous operation.
- BUSY: wait for `mul_done=1`. On that edge, register `mul_low`/`mul_high` into `rsp_low`/`rsp_high` and clear `err`.
- RESP: `rsp_valid[gid]=1` for one cycle.
- Operands are captured at transfer. The requester may change `req_x`/`req_y` freely afterwards.
- A requester that holds `req_valid` high after its `rsp_valid` is treated as making a new request.
- Simultaneous `req_valid` from several requesters: `ptr` decides the winner. Losers wait, with no starvation; worst-case wait is `NREQ-1` operations.
- `ena=0`:
  - The FSM, `ptr` and all registers hold.
  - `rsp_valid` is masked to 0. A pending RESP pulse is delivered on the first cycle with `ena=1`, exactly once.
  - `mul_rst_n` holds its registered value.
- Reset, asynchronous, including mid-operation:
  - State returns to IDLE, `ptr=0`, `gid=0`.
  - `mul_rst_n=1`, `mul_x=mul_y=0`.
  - `rsp_valid=0`, `rsp_low=rsp_high=0`, `rsp_err=0`, `busy=0`.
  - An in-flight operation is dropped with no response.

## Timing
- Transfer in cycle T:
  - T+1: START.
  - T+2: GUARD.
  - T+3 onward: BUSY.
- `mul_done` sampled high in cycle D: RESP in D+1, and a new transfer is possible in D+2.
- Total latency is `L_mul + 3` cycles, where `L_mul` counts cycles from the rising edge of `mul_rst_n` to `mul_done` (all with `ena=1`).
- `req_ready` is asserted only in IDLE. Maximum throughput is one operation per `L_mul + 4` cycles.

## Configuration
- `P256_MUL_ARB_TIMEOUT_EN` defined:
  - A counter runs in BUSY.
  - If it reaches `TIMEOUT_CYCLES` without `mul_done`, the FSM goes to RESP with `rsp_err=1` and `rsp_low=rsp_high=0`.
  - `mul_rst_n` is also pulsed low for that same cycle to abort the multiplier.
- Not defined: no counter is built, `rsp_err` is tied to 0, and BUSY waits indefinitely.

## Structure
- Shared package `p256_pkg`:
  - `P256_W = 256`.
  - FSM state enum: IDLE, START, GUARD, BUSY, RESP.
  - Default `NREQ` and `TIMEOUT_CYCLES`.
- Sub-module `p256_rr_arbiter`:
  - Owns the `ptr` register.
  - Combinational one-hot grant from `req_valid` and `ptr`, with an `advance` input.
- Top level: FSM, operand/result registers, watchdog.

## Test plan
Bench multiplier model: fixed `L_mul = 10`, low-active start, single-cycle done.
- Single op: requester 0 sends `x=3`, `y=5` → one `rsp_valid[0]` pulse 13 cycles after transfer; `rsp_low=15`, `rsp_high=0`; `rsp_valid[1]` never high.
- Max operands: requester 1 sends `x=y=2^256-1` → `rsp_high=2^256-2`, `rsp_low=1`.
- Simultaneous requests right after reset → grants in order 0 then 1. With both held valid continuously, grants alternate 0,1,0,1, and every response goes to the correct requester.
- Stall: `ena=0` for 5 cycles mid-BUSY and again during RESP → latency stretches by the stalled cycles, and exactly one `rsp_valid` pulse is produced per op.
- Async reset 4 cycles into BUSY → all outputs take their reset values immediately. A following request from requester 1 completes normally and returns its correct product.
- With `P256_MUL_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES=20`, model never asserts done → `rsp_valid` with `rsp_err=1` after 20 BUSY cycles, `mul_rst_n` pulses low once, and the next op succeeds with `rsp_err=0`.

Source files
------------

// File: rtl/p256_pkg.sv
// Shared definitions for the P-256 multiplier arbitration slice.
//
// Contents:
//   P256_W            operand / product-half width
//   P256_NREQ_DEF     default number of requesters sharing the multiplier
//   P256_TIMEOUT_DEF  default watchdog limit in BUSY cycles
//   arb_state_e       arbiter FSM state encoding
package p256_pkg;

  localparam int P256_W           = 256;
  localparam int P256_NREQ_DEF    = 2;
  localparam int P256_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    GUARD = 3'd2,
    BUSY  = 3'd3,
    RESP  = 3'd4
  } arb_state_e;

endpackage : p256_pkg

// File: rtl/p256_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//
// The grant goes to the first valid requester at or after ptr, searching
// upward and wrapping modulo NREQ. When advance is high the pointer moves to
// one past the current winner, so the winner gets lowest priority next time.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (ptr returns to 0)
//   req_valid   per-requester request vector
//   advance     accept the current grant this cycle (moves ptr)
//   grant       combinational one-hot grant (all-zero when nothing valid)
//   grant_idx   binary index of the granted requester (0 when none)
module p256_rr_arbiter
  import p256_pkg::*;
#(
  parameter int NREQ  = P256_NREQ_DEF,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req_valid,
  input  logic             advance,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   slot;
  logic             found;

  // NOTE: every signal written in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    slot      = '0;
    for (int k = 0; k < NREQ; k++) begin
      // Candidate (ptr + k) mod NREQ; one extra bit avoids overflow before
      // the wrap for non-power-of-two NREQ.
      slot = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (slot >= (IDX_W+1)'(NREQ)) begin
        slot = slot - (IDX_W+1)'(NREQ);
      end
      if (!found && req_valid[slot[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = slot[IDX_W-1:0];
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : p256_rr_arbiter

// File: rtl/p256_mul_arbiter.sv
// Shares one 256x256 multiplier (start by low pulse on its rst_n, finish on
// a done strobe) between NREQ requesters.
//
// Flow: IDLE grants one requester and latches its operands, START drives
// mul_rst_n low for one enabled cycle, GUARD ignores mul_done (a stale done
// from the previous run may still be high), BUSY waits for mul_done and
// registers the product, RESP strobes rsp_valid to the granted requester.
// ena=0 freezes every register; rsp_valid is masked so a pending RESP pulse
// is delivered once on the first enabled cycle.
//
// Optional feature, macro P256_MUL_ARB_TIMEOUT_EN: a BUSY watchdog. After
// TIMEOUT_CYCLES BUSY cycles without mul_done the arbiter responds with
// rsp_err=1 and a zero product, and pulses mul_rst_n low in that RESP cycle
// to abort the multiplier. Without the macro rsp_err is constant 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   global enable (0 = hold all state)
//   req_valid/req_ready   per-requester handshake; req_ready is one-hot
//   req_x, req_y          packed operands, requester i at [256*i +: 256]
//   rsp_valid             one-cycle one-hot result strobe
//   rsp_low, rsp_high     product halves, held until the next response
//   rsp_err               watchdog timeout flag, qualified by rsp_valid
//   busy                  FSM not in IDLE
//   mul_x, mul_y          registered multiplier operands
//   mul_rst_n             multiplier start/abort (active low)
//   mul_done, mul_low, mul_high  multiplier completion and result
module p256_mul_arbiter
  import p256_pkg::*;
#(
  parameter int NREQ           = P256_NREQ_DEF,
  parameter int TIMEOUT_CYCLES = P256_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*P256_W-1:0] req_x,
  input  logic [NREQ*P256_W-1:0] req_y,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [P256_W-1:0]      rsp_low,
  output logic [P256_W-1:0]      rsp_high,
  output logic                   rsp_err,
  output logic                   busy,
  output logic [P256_W-1:0]      mul_x,
  output logic [P256_W-1:0]      mul_y,
  output logic                   mul_rst_n,
  input  logic                   mul_done,
  input  logic [P256_W-1:0]      mul_low,
  input  logic [P256_W-1:0]      mul_high
);

  localparam int IDX_W = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("p256_mul_arbiter: NREQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  gid_q, gid_d;
  logic [P256_W-1:0] mul_x_q, mul_x_d;
  logic [P256_W-1:0] mul_y_q, mul_y_d;
  logic              mul_rst_n_q, mul_rst_n_d;
  logic [P256_W-1:0] rsp_low_q, rsp_low_d;
  logic [P256_W-1:0] rsp_high_q, rsp_high_d;

  logic [NREQ-1:0]   grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              transfer;
  logic [P256_W-1:0] sel_x, sel_y;

`ifdef P256_MUL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  p256_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .advance   (transfer),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grants are offered only in an enabled IDLE cycle, so transfer already
  // implies ena and the pointer never moves while frozen.
  assign req_ready = (state_q == IDLE && ena) ? grant : '0;
  assign transfer  = |req_ready;

  // One-hot AND-OR operand select from the grant vector.
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_x = req_x[i*P256_W +: P256_W];
        sel_y = req_y[i*P256_W +: P256_W];
      end
    end
  end

  // Strobe is combinational on the RESP state and masked by ena; RESP only
  // exits on an enabled edge, so the pulse is seen exactly once.
  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && ena && (gid_q == IDX_W'(i));
    end
  end

  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    mul_rst_n_d = mul_rst_n_q;
    rsp_low_d   = rsp_low_q;
    rsp_high_d  = rsp_high_q;
`ifdef P256_MUL_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          state_d     = START;
          gid_d       = grant_idx;
          mul_x_d     = sel_x;
          mul_y_d     = sel_y;
          mul_rst_n_d = 1'b0;   // low throughout START
        end
      end
      START: begin
        state_d     = GUARD;
        mul_rst_n_d = 1'b1;
      end
      GUARD: begin
        state_d = BUSY;
`ifdef P256_MUL_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (mul_done) begin
          state_d    = RESP;
          rsp_low_d  = mul_low;
          rsp_high_d = mul_high;
`ifdef P256_MUL_ARB_TIMEOUT_EN
          err_d      = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Give up: report an error with a zero product and hold the
          // multiplier in reset for the RESP cycle to abort it.
          state_d     = RESP;
          rsp_low_d   = '0;
          rsp_high_d  = '0;
          err_d       = 1'b1;
          mul_rst_n_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
`endif
        end
      end
      RESP: begin
        state_d     = IDLE;
        mul_rst_n_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        mul_rst_n_d = 1'b1;
      end
    endcase
  end

  // NOTE: the operand and result registers are datapath, but they are reset
  // anyway because their zero value after reset is externally visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gid_q       <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      mul_rst_n_q <= 1'b1;
      rsp_low_q   <= '0;
      rsp_high_q  <= '0;
    end else if (ena) begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      mul_rst_n_q <= mul_rst_n_d;
      rsp_low_q   <= rsp_low_d;
      rsp_high_q  <= rsp_high_d;
    end
  end

`ifdef P256_MUL_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (ena) begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign mul_rst_n = mul_rst_n_q;
  assign rsp_low   = rsp_low_q;
  assign rsp_high  = rsp_high_q;

endmodule : p256_mul_arbiter

// File: tb/tb_p256_mul_arbiter.sv
// Self-checking bench for p256_mul_arbiter with a fixed-latency multiplier
// model (L_mul = 10, low-active start, single-cycle done, frozen by ena).
// Timeout scenario runs only when P256_MUL_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_p256_mul_arbiter;
  import p256_pkg::*;

  localparam int NREQ  = 2;
  localparam int TO    = 20;
  localparam int L_MUL = 10;
  localparam int W     = P256_W;
  localparam int LAT   = L_MUL + 3;

  typedef logic [W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ena = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x = '0;
  logic [NREQ*W-1:0] req_y = '0;
  logic [NREQ-1:0]   rsp_valid;
  word_t             rsp_low, rsp_high, mul_x, mul_y, mul_low, mul_high;
  logic              rsp_err, busy, mul_rst_n, mul_done;

  always #5 clk = ~clk;

  p256_mul_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_low   (rsp_low),
    .rsp_high  (rsp_high),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_rst_n (mul_rst_n),
    .mul_done  (mul_done),
    .mul_low   (mul_low),
    .mul_high  (mul_high)
  );

  // Multiplier model: reset while mul_rst_n low, done L_MUL cycles after
  // mul_rst_n rises; mul_hang suppresses done.
  int    m_cnt = 0;
  logic  m_run = 1'b0;
  logic  m_done = 1'b0;
  word_t m_lo = '0, m_hi = '0;
  logic  mul_hang = 1'b0;

  always @(posedge clk) begin
    if (ena) begin
      if (!mul_rst_n) begin
        m_cnt  <= 0;
        m_run  <= 1'b1;
        m_done <= 1'b0;
      end else if (m_run) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt + 1 == L_MUL && !mul_hang) begin
          m_done         <= 1'b1;
          m_run          <= 1'b0;
          {m_hi, m_lo}   <= 512'(mul_x) * 512'(mul_y);
        end
      end else begin
        m_done <= 1'b0;
      end
    end
  end

  assign mul_done = m_done;
  assign mul_low  = m_lo;
  assign mul_high = m_hi;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    ena = 1'b1;
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  // One operation from requester id; ena is dropped for cycles
  // [s1, s1+slen) and [s2, s2+slen) counted from the transfer cycle T (k = 1
  // is T+1). Observes a fixed 30-cycle window after the transfer.
  task automatic run_op(input int id, input word_t x, input word_t y,
                        input int s1, input int s2, input int slen,
                        output int lat, output int pulses,
                        output logic [NREQ-1:0] vec, output word_t lo,
                        output word_t hi, output logic err, output int lows);
    int n;
    lat = 0; pulses = 0; vec = '0; lo = '0; hi = '0; err = 1'b0; lows = 0;
    req_x[id*W +: W] = x;
    req_y[id*W +: W] = y;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 50) begin
      step();
      n++;
    end
    check("op_accept", req_ready[id], 1'b1);
    if (!req_ready[id]) begin
      req_valid[id] = 1'b0;
      return;
    end
    step();
    req_valid[id] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      ena = !((k >= s1 && k < s1 + slen) || (k >= s2 && k < s2 + slen));
      #1;
      if (k >= 2 && !mul_rst_n) lows++;
      if (rsp_valid != '0) begin
        pulses++;
        lat = k;
        vec = rsp_valid;
        lo  = rsp_low;
        hi  = rsp_high;
        err = rsp_err;
      end
      step();
    end
    ena = 1'b1;
  endtask

  typedef struct {
    int    id;
    word_t x;
    word_t y;
    word_t exp_lo;
    word_t exp_hi;
  } vec_t;

  vec_t            vecs[5];
  int              lat, pulses, lows, n, win, j;
  logic [NREQ-1:0] vec, exp_ready, exp_rsp, acc, mv;
  word_t           lo, hi, ones, big;
  logic            err;
  word_t           rx[NREQ], ry[NREQ];
  logic [511:0]    cur_p;
  int              ptr_m, due, idle_from, cur;
  word_t           alt_x[NREQ], alt_y[NREQ];
  logic [511:0]    alt_p[NREQ];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ones = '1;
    big  = '0;
    big[128] = 1'b1;
    big[0]   = 1'b1;
    vecs[0] = '{0, word_t'(3), word_t'(5), word_t'(15), word_t'(0)};
    vecs[1] = '{1, ones, ones, word_t'(1), {{(W-1){1'b1}}, 1'b0}};
    vecs[2] = '{0, word_t'(0), ones, word_t'(0), word_t'(0)};
    vecs[3] = '{1, {1'b1, {(W-1){1'b0}}}, word_t'(2), word_t'(0), word_t'(1)};
    // (2^128+1)^2 = 2^256 + 2^129 + 1
    vecs[4] = '{0, big, big, (word_t'(1) << 129) | word_t'(1), word_t'(1)};

    // Reset state and the ena gate on req_ready.
    do_reset();
    check("rst_busy", busy, 1'b0);
    check("rst_mul_rst_n", mul_rst_n, 1'b1);
    check("rst_mul_x", mul_x, '0);
    check("rst_mul_y", mul_y, '0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_low", rsp_low, '0);
    check("rst_rsp_high", rsp_high, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_ready_idle", req_ready, '0);
    ena = 1'b0;
    req_valid = 2'b10;
    #1;
    check("ready_ena0", req_ready, '0);
    ena = 1'b1;
    #1;
    check("ready_ena1", req_ready, 2'b10);
    req_valid = '0;
    #1;

    // Table-driven single operations.
    foreach (vecs[i]) begin
      run_op(vecs[i].id, vecs[i].x, vecs[i].y, 0, 0, 0, lat, pulses, vec, lo, hi, err, lows);
      check($sformatf("tbl%0d_lat", i), lat, LAT);
      check($sformatf("tbl%0d_pulses", i), pulses, 1);
      check($sformatf("tbl%0d_vec", i), vec, oh(vecs[i].id));
      check($sformatf("tbl%0d_low", i), lo, vecs[i].exp_lo);
      check($sformatf("tbl%0d_high", i), hi, vecs[i].exp_hi);
      check($sformatf("tbl%0d_err", i), err, 1'b0);
    end

    // Stall 5 cycles in BUSY and 5 cycles in RESP: 13 + 5 + 5.
    run_op(0, word_t'(1000), word_t'(77), 5, 18, 5, lat, pulses, vec, lo, hi, err, lows);
    check("stall_lat", lat, LAT + 10);
    check("stall_pulses", pulses, 1);
    check("stall_vec", vec, oh(0));
    check("stall_low", lo, word_t'(77000));

    // Async reset four cycles into BUSY (BUSY starts at T+3).
    req_x[0 +: W] = word_t'(16'h1234);
    req_y[0 +: W] = word_t'(16'h0010);
    req_valid[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 50) begin step(); n++; end
    check("rstmid_accept", req_ready[0], 1'b1);
    step();
    req_valid[0] = 1'b0;
    repeat (6) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_mul_rst_n", mul_rst_n, 1'b1);
    check("rstmid_mul_x", mul_x, '0);
    check("rstmid_rsp_valid", rsp_valid, '0);
    check("rstmid_rsp_low", rsp_low, '0);
    check("rstmid_rsp_high", rsp_high, '0);
    check("rstmid_rsp_err", rsp_err, 1'b0);
    step();
    rst_n = 1'b1;
    #1;
    run_op(1, word_t'(123457), word_t'(654321), 0, 0, 0, lat, pulses, vec, lo, hi, err, lows);
    check("after_rst_pulses", pulses, 1);
    check("after_rst_vec", vec, oh(1));
    check("after_rst_low", lo, word_t'(64'd123457 * 64'd654321));
    check("after_rst_lat", lat, LAT);

    // Both requesters valid right after reset and held: grants 0,1,0,1.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      alt_x[i] = word_t'(7 + 6 * i);
      alt_y[i] = word_t'(11 + 6 * i);
      alt_p[i] = 512'(alt_x[i]) * 512'(alt_y[i]);
      req_x[i*W +: W] = alt_x[i];
      req_y[i*W +: W] = alt_y[i];
    end
    req_valid = '1;
    #1;
    for (int op = 0; op < 4; op++) begin
      n = 0;
      while (req_ready == '0 && n < 40) begin step(); n++; end
      check($sformatf("alt%0d_grant", op), req_ready, oh(op % NREQ));
      step();
      n = 0;
      while (rsp_valid == '0 && n < 40) begin step(); n++; end
      check($sformatf("alt%0d_rsp_vec", op), rsp_valid, oh(op % NREQ));
      check($sformatf("alt%0d_rsp_low", op), {rsp_high, rsp_low}, alt_p[op % NREQ]);
      step();
    end
    req_valid = '0;
    #1;

`ifdef P256_MUL_ARB_TIMEOUT_EN
    // Multiplier never finishes: error response after TO BUSY cycles.
    mul_hang = 1'b1;
    run_op(0, word_t'(9), word_t'(9), 0, 0, 0, lat, pulses, vec, lo, hi, err, lows);
    mul_hang = 1'b0;
    check("to_lat", lat, TO + 3);
    check("to_pulses", pulses, 1);
    check("to_err", err, 1'b1);
    check("to_low", lo, '0);
    check("to_high", hi, '0);
    check("to_abort_lows", lows, 1);
    run_op(1, word_t'(9), word_t'(9), 0, 0, 0, lat, pulses, vec, lo, hi, err, lows);
    check("to_next_err", err, 1'b0);
    check("to_next_low", lo, word_t'(81));
`endif

    // Randomised traffic against a timing/priority reference model.
    do_reset();
    ptr_m = 0; due = -1; idle_from = 0; cur = 0; cur_p = '0;
    acc = '0; mv = '0;
    for (int i = 0; i < NREQ; i++) begin rx[i] = '0; ry[i] = '0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) mv[i] = 1'b0;
        else if (!mv[i] && $urandom_range(0, 2) == 0) begin
          rx[i] = ($urandom_range(0, 7) == 0) ? '1 : rand_word();
          ry[i] = rand_word();
          mv[i] = 1'b1;
        end
      end
      acc = '0;
      req_valid = mv;
      for (int i = 0; i < NREQ; i++) begin
        req_x[i*W +: W] = rx[i];
        req_y[i*W +: W] = ry[i];
      end
      #1;
      exp_ready = '0;
      win = -1;
      if (cyc >= idle_from) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (ptr_m + k) % NREQ;
          if (win < 0 && mv[j]) win = j;
        end
      end
      if (win >= 0) exp_ready = oh(win);
      exp_rsp = (cyc == due) ? oh(cur) : '0;
      check("rnd_ready", req_ready, exp_ready);
      check("rnd_rsp_vec", rsp_valid, exp_rsp);
      if (cyc == due) check("rnd_product", {rsp_high, rsp_low}, cur_p);
      if (win >= 0) begin
        acc       = exp_ready;
        cur       = win;
        cur_p     = 512'(rx[win]) * 512'(ry[win]);
        due       = cyc + LAT;
        idle_from = cyc + LAT + 1;
        ptr_m     = (win + 1) % NREQ;
      end
      step();
    end
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_p256_mul_arbiter
